// File: rtl/mc_controller_fsm.sv
// mc_controller_fsm: multicycle MIPS-subset main control unit (Moore FSM).
// Sequences each instruction through fetch/decode/execute/memory/write-back
// and decodes the datapath control lines from the current state only.
// Optional feature: define MC_ADDI_EN to add ADDI (states 10 ADDIEXE, 11 ADDIWB).
module mc_controller_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  output logic [3:0] S,
  output logic [3:0] NS,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       MemToReg,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IorD,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource
);

  localparam int unsigned StateW = 4;
  localparam int unsigned OpW    = 6;

  localparam logic [OpW-1:0] OpLw    = 6'b100011;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;
  localparam logic [OpW-1:0] OpRtype = 6'b000000;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [OpW-1:0] OpAddi  = 6'b001000;
`endif

  typedef enum logic [StateW-1:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADDR = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_RCOMP   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_ADDIEXE = 4'd10,
    ST_ADDIWB  = 4'd11
  } state_e;

  state_e state_q;
  state_e state_d;

  // State register; async reset returns the machine to FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; unknown opcodes and illegal states fall back to FETCH.
  always_comb begin
    state_d = ST_FETCH;
    unique case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (Op)
          OpLw, OpSw: state_d = ST_MEMADDR;
          OpRtype:    state_d = ST_EXEC;
          OpBeq:      state_d = ST_BRANCH;
          OpJ:        state_d = ST_JUMP;
`ifdef MC_ADDI_EN
          OpAddi:     state_d = ST_ADDIEXE;
`endif
          default:    state_d = ST_FETCH;
        endcase
      end
      ST_MEMADDR: state_d = (Op == OpLw) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:   state_d = ST_MEMWB;
      ST_EXEC:    state_d = ST_RCOMP;
`ifdef MC_ADDI_EN
      ST_ADDIEXE: state_d = ST_ADDIWB;
`endif
      default:    state_d = ST_FETCH;
    endcase
  end

  // Moore output decode from the current state; unlisted controls stay 0.
  always_comb begin
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    IorD        = 1'b0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    unique case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      ST_DECODE:  ALUSrcB = 2'b11;
      ST_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ST_RCOMP: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`ifdef MC_ADDI_EN
      ST_ADDIEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ST_ADDIWB: RegWrite = 1'b1;
`endif
      default: ;
    endcase
  end

  assign S  = state_q;
  assign NS = state_d;

endmodule

// File: tb/tb_mc_controller_fsm.sv
// tb_mc_controller_fsm: table-driven opcode sequences checked through a
// scoreboard queue, plus hand-written reset corner cases.
module tb_mc_controller_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic [3:0] S, NS;
  logic       RegDst, RegWrite, ALUSrcA, MemToReg, IRWrite, MemWrite;
  logic       MemRead, IorD, PCWriteCond, PCWrite;
  logic [1:0] ALUSrcB, ALUOp, PCSource;

  mc_controller_fsm dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .S(S), .NS(NS),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .MemToReg(MemToReg), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .IorD(IorD), .PCWriteCond(PCWriteCond),
    .PCWrite(PCWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  logic [15:0] act_ctrl;
  assign act_ctrl = {RegDst, RegWrite, ALUSrcA, MemToReg, IRWrite, MemWrite,
                     MemRead, IorD, PCWriteCond, PCWrite, ALUSrcB, ALUOp, PCSource};

  typedef struct packed {
    logic [3:0]  s;
    logic [3:0]  ns;
    logic [15:0] ctrl;
  } exp_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    int         len;
    logic [3:0] seq [6];
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected controls per state, packed in the same order as act_ctrl.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st);
    logic [15:0] c;
    c = 16'h0000;
    case (st)
      4'd0:  c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00};
      4'd1:  c = {10'b0, 2'b11, 2'b00, 2'b00};
      4'd2:  c = {2'b00, 1'b1, 7'b0, 2'b10, 2'b00, 2'b00};
      4'd3:  c = {6'b0, 1'b1, 1'b1, 2'b00, 6'b0};
      4'd4:  c = {1'b0, 1'b1, 1'b0, 1'b1, 6'b0, 6'b0};
      4'd5:  c = {5'b0, 1'b1, 1'b0, 1'b1, 2'b00, 6'b0};
      4'd6:  c = {2'b00, 1'b1, 7'b0, 2'b00, 2'b10, 2'b00};
      4'd7:  c = {2'b11, 8'b0, 6'b0};
      4'd8:  c = {2'b00, 1'b1, 5'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01};
      4'd9:  c = {9'b0, 1'b1, 2'b00, 2'b00, 2'b10};
`ifdef MC_ADDI_EN
      4'd10: c = {2'b00, 1'b1, 7'b0, 2'b10, 2'b00, 2'b00};
      4'd11: c = {1'b0, 1'b1, 8'b0, 6'b0};
`endif
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one instruction from FETCH; each cycle pushes the expectation,
  // and the DUT is sampled and popped on the following falling edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   j;
    Op = v.op;
    for (int i = 0; i < v.len; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      j      = (i + 1) % v.len;
      e.s    = v.seq[i];
      e.ns   = v.seq[j];
      e.ctrl = exp_ctrl(v.seq[i]);
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check({v.name, " S"},    {12'h000, S},  {12'h000, e.s});
      check({v.name, " NS"},   {12'h000, NS}, {12'h000, e.ns});
      check({v.name, " ctrl"}, act_ctrl,      e.ctrl);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{name: "rtype",   op: 6'b000000, len: 4, seq: '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}};
    vecs[1] = '{name: "rtype2",  op: 6'b000000, len: 4, seq: '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}};
    vecs[2] = '{name: "lw",      op: 6'b100011, len: 5, seq: '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}};
    vecs[3] = '{name: "sw",      op: 6'b101011, len: 4, seq: '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}};
    vecs[4] = '{name: "beq",     op: 6'b000100, len: 3, seq: '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}};
    vecs[5] = '{name: "j",       op: 6'b000010, len: 3, seq: '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0}};
    vecs[6] = '{name: "unknown", op: 6'b111111, len: 2, seq: '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
`ifdef MC_ADDI_EN
    vecs[7] = '{name: "addi",    op: 6'b001000, len: 4, seq: '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0}};
`else
    vecs[7] = '{name: "addi_off", op: 6'b001000, len: 2, seq: '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}};
`endif

    // Reset state: FETCH outputs and NS=1 while held in reset.
    rst_n = 1'b0;
    Op    = 6'b000000;
    #1;
    check("reset S",    {12'h000, S},  16'h0000);
    check("reset NS",   {12'h000, NS}, 16'h0001);
    check("reset ctrl", act_ctrl,      exp_ctrl(4'd0));
    @(posedge clk);
    #1;
    check("reset hold S", {12'h000, S}, 16'h0000);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Async reset in MEMRD: state must clear without a clock edge.
    Op = 6'b100011;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    check("pre-reset S",    {12'h000, S}, 16'h0003);
    check("pre-reset ctrl", act_ctrl,     exp_ctrl(4'd3));
    rst_n = 1'b0;
    #1;
    check("async S",    {12'h000, S},  16'h0000);
    check("async NS",   {12'h000, NS}, 16'h0001);
    check("async ctrl", act_ctrl,      exp_ctrl(4'd0));
    @(posedge clk);
    #1;
    check("held S", {12'h000, S}, 16'h0000);
    rst_n = 1'b1;
    run_vec(vecs[4]);
    run_vec(vecs[2]);

    check("sb empty", 16'(sb.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 100000);
    $fatal(1);
  end

endmodule
